simd_alu_sequencer: RTL and testbench

- Time-multiplexes one scalar `alu` instance across the lanes of a SIMD vector operation.
- Accepts a vector opcode plus two packed vectors, then issues one lane per cycle to the ALU.
- Collects per-lane results and neg/zero flags into a packed result vector.
- Sits between the vector execute stage and the shared `alu`; the `alu` stays purely combinational.

---
 rtl/simd_alu_sequencer_if.sv | 26 ++
 rtl/simd_alu_sequencer.sv | 101 ++++++++++
 tb/tb_simd_alu_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/simd_alu_sequencer_if.sv
// Vector-side handshake between the execute stage and the SIMD ALU sequencer.
// The execute stage is the master; the sequencer is the slave.
interface simd_alu_sequencer_if #(
   parameter int dataSize = 8,
   parameter int lanes    = 4
);
   logic                      start;
   logic [2:0]                opcode;
   logic [lanes*dataSize-1:0] vecA;
   logic [lanes*dataSize-1:0] vecB;
   logic                      ready;
   logic                      done;
   logic [lanes*dataSize-1:0] vecResult;
   logic [lanes-1:0]          negMask;
   logic [lanes-1:0]          zeroMask;

   modport master (
      output start, opcode, vecA, vecB,
      input  ready, done, vecResult, negMask, zeroMask
   );

   modport slave (
      input  start, opcode, vecA, vecB,
      output ready, done, vecResult, negMask, zeroMask
   );
endinterface

// File: rtl/simd_alu_sequencer.sv
// Issues the lanes of a vector op one per cycle to a shared combinational
// scalar ALU and gathers the per-lane results and neg/zero flags.
module simd_alu_sequencer #(
   parameter int dataSize = 8,
   parameter int lanes    = 4
) (
   input  logic                clk,
   input  logic                rst,
   simd_alu_sequencer_if.slave vec,
   output logic [2:0]          alu_op,
   output logic [dataSize-1:0] alu_a,
   output logic [dataSize-1:0] alu_b,
   input  logic [dataSize-1:0] alu_result,
   input  logic                alu_neg,
   input  logic                alu_zero
);
   localparam int LW = (lanes > 1) ? $clog2(lanes) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(lanes - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [LW-1:0]             lane_q;
   logic [2:0]                op_q;
   logic [lanes*dataSize-1:0] a_q, b_q;
   logic [lanes*dataSize-1:0] res_q;
   logic [lanes-1:0]          neg_q, zero_q;
   logic                      ready_c, done_c;

   assign vec.ready     = ready_c;
   assign vec.done      = done_c;
   assign vec.vecResult = res_q;
   assign vec.negMask   = neg_q;
   assign vec.zeroMask  = zero_q;

   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      done_c  = 1'b0;
      alu_op  = 3'b000;
      alu_a   = '0;
      alu_b   = '0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (vec.start) state_d = (vec.opcode == 3'b000) ? DONE : ISSUE;
         end
         ISSUE: begin
            alu_op = op_q;
            alu_a  = a_q[lane_q*dataSize +: dataSize];
            alu_b  = b_q[lane_q*dataSize +: dataSize];
            if (lane_q == LAST_LANE) state_d = DONE;
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result registers are cleared on reset too, so an aborted op leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lane_q  <= '0;
         op_q    <= 3'b000;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         neg_q   <= '0;
         zero_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (vec.start) begin
                  neg_q  <= '0;
                  zero_q <= '0;
                  lane_q <= '0;
                  if (vec.opcode == 3'b000) begin
                     res_q <= vec.vecA;
                  end else begin
                     op_q  <= vec.opcode;
                     a_q   <= vec.vecA;
                     b_q   <= vec.vecB;
                     res_q <= '0;
                  end
               end
            end
            ISSUE: begin
               res_q[lane_q*dataSize +: dataSize] <= alu_result;
               neg_q[lane_q]  <= alu_neg;
               zero_q[lane_q] <= alu_zero;
               if (lane_q != LAST_LANE) lane_q <= lane_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_simd_alu_sequencer.sv
// Bench for simd_alu_sequencer: directed vector table, multi-cycle corner
// sequences and randomized ops against a lane-by-lane reference model.
module tb_simd_alu_sequencer;
   localparam int DS = 8;
   localparam int LN = 4;
   localparam int VW = DS * LN;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    alu_op;
   logic [DS-1:0] alu_a, alu_b, alu_result;
   logic          alu_neg, alu_zero;

   int pass_cnt = 0;
   int total_cnt = 0;
   int done_pulses = 0;

   simd_alu_sequencer_if #(.dataSize(DS), .lanes(LN)) vif ();

   simd_alu_sequencer #(.dataSize(DS), .lanes(LN)) dut (
      .clk        (clk),
      .rst        (rst),
      .vec        (vif.slave),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_neg    (alu_neg),
      .alu_zero   (alu_zero)
   );

   always #5 clk = ~clk;

   // Scalar ALU seen by the sequencer: purely combinational.
   function automatic logic [DS-1:0] alu_f(input logic [2:0] op, input logic [DS-1:0] a, input logic [DS-1:0] b);
      logic [2*DS-1:0] p;
      p = a * b;
      case (op)
         3'd1: return a ^ b;
         3'd2: return a + b;
         3'd3: return a - b;
         3'd4: return p[DS-1:0];
         3'd5: return a >> b[2:0];
         3'd6: return a << b[2:0];
         3'd7: return a + 8'd1;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_f(alu_op, alu_a, alu_b);
      alu_neg    = alu_result[DS-1];
      alu_zero   = (alu_result == '0);
   end

   always @(negedge clk) if (vif.done) done_pulses++;

   // Reference: whole-vector result of an op, lane by lane.
   task automatic ref_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output logic [VW-1:0] res, output logic [LN-1:0] neg, output logic [LN-1:0] zero);
      logic [DS-1:0] r;
      res = '0; neg = '0; zero = '0;
      if (op == 3'b000) begin
         res = a;
      end else begin
         for (int i = 0; i < LN; i++) begin
            r = alu_f(op, a[i*DS +: DS], b[i*DS +: DS]);
            res[i*DS +: DS] = r;
            neg[i]  = r[DS-1];
            zero[i] = (r == '0);
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   // mode 0: plain; 1: busy start (xor) raised one cycle after issue begins;
   // 2: vecA overwritten with 0xFF lanes right after accept.
   task automatic run_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b, input int mode,
                         output int lat, output int issue_cnt, output logic ready_after);
      @(negedge clk);
      vif.start = 1'b1; vif.opcode = op; vif.vecA = a; vif.vecB = b;
      @(posedge clk); #1;
      vif.start = 1'b0;
      if (mode == 2) vif.vecA = '1;
      issue_cnt = (alu_op != 3'b000) ? 1 : 0;
      lat = 0;
      if (!vif.done) begin
         lat = 99;
         for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (mode == 1 && n == 1) begin
               vif.start = 1'b1; vif.opcode = 3'b001;
            end
            if (vif.done) begin
               lat = n;
               if (alu_op != 3'b000) issue_cnt += 100;
               break;
            end
            if (alu_op != 3'b000) issue_cnt++;
         end
      end
      vif.start = 1'b0;
      @(posedge clk); #1;
      ready_after = vif.ready & ~vif.done;
   endtask

   typedef struct {
      logic [2:0]    op;
      logic [VW-1:0] a, b, res;
      logic [LN-1:0] neg, zero;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int lat, ic, pulses0;
      logic rdy;
      logic [VW-1:0] er;
      logic [LN-1:0] en, ez;

      tbl[0] = '{3'b010, 32'h04030201, 32'h01010101, 32'h05040302, 4'b0000, 4'b0000};
      tbl[1] = '{3'b011, 32'h00050301, 32'h00020303, 32'h000300FE, 4'b0001, 4'b1010};
      tbl[2] = '{3'b000, 32'h09080706, 32'h12345678, 32'h09080706, 4'b0000, 4'b0000};
      tbl[3] = '{3'b100, 32'h03030303, 32'h02020202, 32'h06060606, 4'b0000, 4'b0000};
      tbl[4] = '{3'b001, 32'hFF0F00AA, 32'h0F0F0055, 32'hF00000FF, 4'b1001, 4'b0110};
      tbl[5] = '{3'b111, 32'h7FFF0001, 32'h00000000, 32'h80000102, 4'b1000, 4'b0100};
      tbl[6] = '{3'b110, 32'h81010280, 32'h01010101, 32'h02020400, 4'b0000, 4'b0001};
      tbl[7] = '{3'b101, 32'h80F00201, 32'h07040101, 32'h010F0100, 4'b0000, 4'b0001};

      vif.start = 1'b0; vif.opcode = 3'b000; vif.vecA = '0; vif.vecB = '0;
      #2;
      chk("reset_ready", 64'(vif.ready), 64'd1);
      chk("reset_done", 64'(vif.done), 64'd0);
      chk("reset_result", 64'(vif.vecResult), 64'd0);
      chk("reset_masks", 64'({vif.negMask, vif.zeroMask}), 64'd0);
      chk("reset_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, lat, ic, rdy);
         chk($sformatf("tbl%0d_latency", i), 64'(lat), (tbl[i].op == 3'b000) ? 64'd0 : 64'(LN));
         chk($sformatf("tbl%0d_issue_cycles", i), 64'(ic), (tbl[i].op == 3'b000) ? 64'd0 : 64'(LN));
         chk($sformatf("tbl%0d_result", i), 64'(vif.vecResult), 64'(tbl[i].res));
         chk($sformatf("tbl%0d_neg", i), 64'(vif.negMask), 64'(tbl[i].neg));
         chk($sformatf("tbl%0d_zero", i), 64'(vif.zeroMask), 64'(tbl[i].zero));
         chk($sformatf("tbl%0d_ready_after", i), 64'(rdy), 64'd1);
      end

      // Busy start: xor request during an add must be ignored.
      pulses0 = done_pulses;
      run_op(3'b010, 32'h04030201, 32'h01010101, 1, lat, ic, rdy);
      chk("busy_latency", 64'(lat), 64'(LN));
      chk("busy_result", 64'(vif.vecResult), 64'h05040302);
      chk("busy_ready_after", 64'(rdy), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_done_pulses", 64'(done_pulses - pulses0), 64'd1);

      // Operand stability: vecA changed after accept of mul.
      run_op(3'b100, 32'h03030303, 32'h02020202, 2, lat, ic, rdy);
      chk("stable_result", 64'(vif.vecResult), 64'h06060606);

      // Reset during lane 2 of an add.
      @(negedge clk);
      vif.start = 1'b1; vif.opcode = 3'b010; vif.vecA = 32'h04030201; vif.vecB = 32'h01010101;
      @(posedge clk); #1;
      vif.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midop_partial", 64'(vif.vecResult), 64'h00000302);
      pulses0 = done_pulses;
      #2 rst = 1'b1;
      #1;
      chk("midop_result", 64'(vif.vecResult), 64'd0);
      chk("midop_masks", 64'({vif.negMask, vif.zeroMask}), 64'd0);
      chk("midop_ready", 64'(vif.ready), 64'd1);
      chk("midop_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midop_no_done", 64'(done_pulses - pulses0), 64'd0);
      run_op(tbl[1].op, tbl[1].a, tbl[1].b, 0, lat, ic, rdy);
      chk("after_reset_latency", 64'(lat), 64'(LN));
      chk("after_reset_result", 64'(vif.vecResult), 64'(tbl[1].res));
      chk("after_reset_masks", 64'({vif.negMask, vif.zeroMask}), 64'({tbl[1].neg, tbl[1].zero}));

      // Randomized ops against the reference.
      for (int k = 0; k < 40; k++) begin
         logic [2:0] op;
         logic [VW-1:0] a, b;
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         ref_op(op, a, b, er, en, ez);
         run_op(op, a, b, 0, lat, ic, rdy);
         chk($sformatf("rand%0d_latency", k), 64'(lat), (op == 3'b000) ? 64'd0 : 64'(LN));
         chk($sformatf("rand%0d_result", k), 64'(vif.vecResult), 64'(er));
         chk($sformatf("rand%0d_masks", k), 64'({vif.negMask, vif.zeroMask}), 64'({en, ez}));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
